mult_booth_r4_seq: RTL

- Parametrised iterative radix-4 Booth multiplier; sequential successor to the 4-bit combinational `multiplier_4bits_*` family.
- Multiplies two WIDTH-bit operands, signed or unsigned (selected per transaction), one Booth digit per clock.
- Valid/ready handshakes on input and output.
- Sits in the multiplier library as the area-optimised option for datapaths that tolerate multi-cycle latency.

---
 rtl/mult_pkg.sv | 34 +++
 rtl/booth_r4_pp.sv | 24 ++
 rtl/mult_booth_r4_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } mult_state_e;

   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } booth_digit_e;

   function automatic booth_digit_e booth_encode(input logic [2:0] bits);
      booth_digit_e d;
      case (bits)
         3'b001, 3'b010: d = POS1;
         3'b011:         d = POS2;
         3'b100:         d = NEG2;
         3'b101, 3'b110: d = NEG1;
         default:        d = ZERO;
      endcase
      return d;
   endfunction

   function automatic int iter_count(input int width);
      return (width + 2) / 2;
   endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Partial-product selector: maps one Booth digit onto the
// pre-shifted multiplicand.
module booth_r4_pp
   import mult_pkg::*;
#(
   parameter int AW = 20
) (
   input  booth_digit_e            digit,
   input  logic signed [AW-1:0]    mcand,
   output logic signed [AW-1:0]    addend
);

   always_comb begin
      addend = '0;
      unique case (digit)
         POS1:    addend = mcand;
         POS2:    addend = mcand <<< 1;
         NEG1:    addend = -mcand;
         NEG2:    addend = -(mcand <<< 1);
         default: addend = '0;
      endcase
   end

endmodule

// File: rtl/mult_booth_r4_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock,
// valid/ready on both sides.
module mult_booth_r4_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int ITER = iter_count(WIDTH);
   localparam int AW   = 2*WIDTH + 4;
   localparam int CW   = $clog2(ITER + 1);

   if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("mult_booth_r4_seq: WIDTH must be even and >= 4");
   end

   mult_state_e         state;
   logic [CW-1:0]       cnt;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] mcand;
   logic [WIDTH+1:0]    mplr;
   logic                mprev;

   booth_digit_e        digit;
   logic signed [AW-1:0] addend;
   logic signed [AW-1:0] acc_nxt;
   logic                a_ext;
   logic                b_ext;

   assign digit   = booth_encode({mplr[1], mplr[0], mprev});
   assign acc_nxt = acc + addend;
   assign a_ext   = is_signed & A[WIDTH-1];
   assign b_ext   = is_signed & B[WIDTH-1];

   booth_r4_pp #(
      .AW (AW)
   ) u_pp (
      .digit  (digit),
      .mcand  (mcand),
      .addend (addend)
   );

   // Multiplicand moves up two bits per digit instead of a
   // variable shifter; multiplier moves down to expose the next triple.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplr      <= '0;
         mprev     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         product   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  mcand    <= {{(AW-WIDTH){a_ext}}, A};
                  mplr     <= {{2{b_ext}}, B};
                  mprev    <= 1'b0;
                  acc      <= '0;
                  cnt      <= CW'(ITER);
                  state    <= CALC;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            CALC: begin
               acc   <= acc_nxt;
               mcand <= mcand <<< 2;
               mplr  <= mplr >> 2;
               mprev <= mplr[1];
               cnt   <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  product   <= acc_nxt[2*WIDTH-1:0];
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
